// File: rtl/control_unit.sv
// Multicycle control FSM: walks fetch/decode/execute/writeback and drives the datapath
// control lines as a pure function of the current state and the held instruction.
module control_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction_in,
  input  logic        alu_zero,
  input  logic        alu_equal,
  input  logic        alu_greater,
  input  logic        alu_less,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        PCWriteState,
  output logic        PCSource,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [3:0]  ALUOp,
  output logic        LoadAOut,
  output logic        RegWrite,
  output logic        LoadRegA,
  output logic        LoadRegB,
  output logic [1:0]  MemToReg,
  output logic        DMemOp,
  output logic        LoadMDR,
  output logic [1:0]  LoadSplice,
  output logic [1:0]  StoreSplice,
  output logic        IMemRead,
  output logic        IRWrite,
  output logic        EPCWrite,
  output logic        CauseWrite,
  output logic        IntCause,
  output logic        halted
);

  localparam logic [3:0] OpAdd = 4'b0001;
  localparam logic [3:0] OpSub = 4'b0010;
  localparam logic [3:0] OpAnd = 4'b0011;
  localparam logic [3:0] OpOr  = 4'b0100;
  localparam logic [3:0] OpXor = 4'b0101;

  typedef enum logic [4:0] {
    StFetch, StIrLoad, StDecode, StExecR, StExecI, StExecLui, StWbAlu, StMemAddr,
    StMemRead, StMemWait, StWbMem, StMemWrite, StBranch, StJalLink, StJalWb, StPcInc,
    StExc, StHalt
  } state_e;

  state_e state_q, state_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  assign opcode = instruction_in[6:0];
  assign funct3 = instruction_in[14:12];
  assign funct7 = instruction_in[31:25];

  // Register/immediate fields belong to the datapath; alu_zero has no consumer here.
  logic unused_inputs;
  assign unused_inputs = ^{alu_zero, instruction_in[24:15], instruction_in[11:7]};

  logic [3:0] r_op;
  logic       r_ok;
  always_comb begin
    r_op = OpAdd;
    r_ok = 1'b1;
    case (funct3)
      3'b000: begin
        if (funct7 == 7'b0000000)      r_op = OpAdd;
        else if (funct7 == 7'b0100000) r_op = OpSub;
        else                           r_ok = 1'b0;
      end
      3'b111:  r_op = OpAnd;
      3'b110:  r_op = OpOr;
      3'b100:  r_op = OpXor;
      default: r_ok = 1'b0;
    endcase
  end

  logic taken, br_ok;
  always_comb begin
    taken = 1'b0;
    br_ok = 1'b1;
    case (funct3)
      3'b000:  taken = alu_equal;
      3'b001:  taken = ~alu_equal;
      3'b100:  taken = alu_less;
      3'b101:  taken = alu_greater | alu_equal;
      default: br_ok = 1'b0;
    endcase
  end

  // Access size: double/word/half/byte map to 00/01/10/11; funct3[2] set is illegal.
  logic [1:0] splice;
  logic       size_ok;
  assign splice  = 2'd3 - funct3[1:0];
  assign size_ok = ~funct3[2];

  logic pc_write, pc_write_cond, reg_write, dmem_op, ir_write, epc_write, cause_write;

  always_comb begin
    state_d       = state_q;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    reg_write     = 1'b0;
    dmem_op       = 1'b0;
    ir_write      = 1'b0;
    epc_write     = 1'b0;
    cause_write   = 1'b0;
    PCSource      = 1'b0;
    ALUSrcA       = 2'b00;
    ALUSrcB       = 2'b00;
    ALUOp         = 4'b0000;
    LoadAOut      = 1'b0;
    LoadRegA      = 1'b0;
    LoadRegB      = 1'b0;
    MemToReg      = 2'b00;
    LoadMDR       = 1'b0;
    LoadSplice    = 2'b00;
    StoreSplice   = 2'b00;
    IMemRead      = 1'b0;
    IntCause      = 1'b0;
    halted        = 1'b0;
    case (state_q)
      StFetch: begin
        IMemRead = 1'b1;
        state_d  = StIrLoad;
      end
      StIrLoad: begin
        ir_write = 1'b1;
        state_d  = StDecode;
      end
      StDecode: begin
        // Branch target PC+imm is parked in ALUOut while the opcode is dispatched.
        LoadRegA = 1'b1;
        LoadRegB = 1'b1;
        LoadAOut = 1'b1;
        ALUSrcB  = 2'b10;
        ALUOp    = OpAdd;
        case (opcode)
          7'b0110011:             state_d = StExecR;
          7'b0010011:             state_d = StExecI;
          7'b0110111:             state_d = StExecLui;
          7'b0000011, 7'b0100011: state_d = size_ok ? StMemAddr : StExc;
          7'b1100011:             state_d = StBranch;
          7'b1101111:             state_d = StJalLink;
          7'b1110011:             state_d = StHalt;
          default:                state_d = StExc;
        endcase
      end
      StExecR: begin
        if (r_ok) begin
          ALUSrcA  = 2'b01;
          ALUOp    = r_op;
          LoadAOut = 1'b1;
        end
        state_d = r_ok ? StWbAlu : StExc;
      end
      StExecI: begin
        if (funct3 == 3'b000) begin
          ALUSrcA  = 2'b01;
          ALUSrcB  = 2'b10;
          ALUOp    = OpAdd;
          LoadAOut = 1'b1;
        end
        state_d = (funct3 == 3'b000) ? StWbAlu : StExc;
      end
      StExecLui: begin
        ALUSrcA  = 2'b10;
        ALUSrcB  = 2'b10;
        ALUOp    = OpAdd;
        LoadAOut = 1'b1;
        state_d  = StWbAlu;
      end
      StWbAlu: begin
        reg_write = 1'b1;
        state_d   = StPcInc;
      end
      StMemAddr: begin
        ALUSrcA  = 2'b01;
        ALUSrcB  = 2'b10;
        ALUOp    = OpAdd;
        LoadAOut = 1'b1;
        state_d  = (opcode == 7'b0100011) ? StMemWrite : StMemRead;
      end
      StMemRead: state_d = StMemWait;
      StMemWait: begin
        LoadMDR = 1'b1;
        state_d = StWbMem;
      end
      StWbMem: begin
        reg_write  = 1'b1;
        MemToReg   = 2'b01;
        LoadSplice = splice;
        state_d    = StPcInc;
      end
      StMemWrite: begin
        dmem_op     = 1'b1;
        StoreSplice = splice;
        state_d     = StPcInc;
      end
      StBranch: begin
        ALUSrcA       = 2'b01;
        ALUOp         = OpSub;
        pc_write_cond = 1'b1;
        PCSource      = 1'b1;
        if (!br_ok)     state_d = StExc;
        else if (taken) state_d = StFetch;
        else            state_d = StPcInc;
      end
      StJalLink, StPcInc: begin
        ALUSrcB  = 2'b01;
        ALUOp    = OpAdd;
        pc_write = 1'b1;
        state_d  = (state_q == StJalLink) ? StJalWb : StFetch;
      end
      StJalWb: begin
        reg_write = 1'b1;
        MemToReg  = 2'b10;
        PCSource  = 1'b1;
        pc_write  = 1'b1;
        state_d   = StFetch;
      end
      StExc: begin
        epc_write   = 1'b1;
        cause_write = 1'b1;
        state_d     = StHalt;
      end
      StHalt:  halted  = 1'b1;
      default: state_d = StFetch;
    endcase
  end

  // Architectural side effects are suppressed for the whole cycle reset is high.
  assign PCWrite      = pc_write & ~reset;
  assign PCWriteCond  = pc_write_cond & ~reset;
  assign PCWriteState = (pc_write | (pc_write_cond & taken)) & ~reset;
  assign RegWrite     = reg_write & ~reset;
  assign DMemOp       = dmem_op & ~reset;
  assign IRWrite      = ir_write & ~reset;
  assign EPCWrite     = epc_write & ~reset;
  assign CauseWrite   = cause_write & ~reset;

  always_ff @(posedge clk) begin
    if (reset) state_q <= StFetch;
    else       state_q <= state_d;
  end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: per-instruction expected control-word sequences built from the
// instruction-class rules, compared cycle by cycle under directed and random instructions.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instruction_in = '0;
  logic        alu_zero = 1'b0, alu_equal = 1'b0, alu_greater = 1'b0, alu_less = 1'b0;
  logic        PCWrite, PCWriteCond, PCWriteState, PCSource;
  logic [1:0]  ALUSrcA, ALUSrcB;
  logic [3:0]  ALUOp;
  logic        LoadAOut, RegWrite, LoadRegA, LoadRegB;
  logic [1:0]  MemToReg;
  logic        DMemOp, LoadMDR;
  logic [1:0]  LoadSplice, StoreSplice;
  logic        IMemRead, IRWrite, EPCWrite, CauseWrite, IntCause, halted;

  control_unit dut (
    .clk(clk), .reset(reset), .instruction_in(instruction_in),
    .alu_zero(alu_zero), .alu_equal(alu_equal), .alu_greater(alu_greater),
    .alu_less(alu_less), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
    .PCWriteState(PCWriteState), .PCSource(PCSource), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .LoadAOut(LoadAOut), .RegWrite(RegWrite),
    .LoadRegA(LoadRegA), .LoadRegB(LoadRegB), .MemToReg(MemToReg), .DMemOp(DMemOp),
    .LoadMDR(LoadMDR), .LoadSplice(LoadSplice), .StoreSplice(StoreSplice),
    .IMemRead(IMemRead), .IRWrite(IRWrite), .EPCWrite(EPCWrite), .CauseWrite(CauseWrite),
    .IntCause(IntCause), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pc_write, pc_write_cond, pc_write_state, pc_source;
    logic [1:0] src_a, src_b;
    logic [3:0] alu_op;
    logic       load_aout, reg_write, load_reg_a, load_reg_b;
    logic [1:0] mem_to_reg;
    logic       dmem_op, load_mdr;
    logic [1:0] load_splice, store_splice;
    logic       imem_read, ir_write, epc_write, cause_write, int_cause, halted;
  } rec_t;

  int   checks = 0;
  int   passed = 0;
  rec_t exp_q[$];
  rec_t zero_rec = '0;

  function automatic rec_t observed();
    rec_t r;
    r.pc_write = PCWrite;        r.pc_write_cond = PCWriteCond;
    r.pc_write_state = PCWriteState; r.pc_source = PCSource;
    r.src_a = ALUSrcA;           r.src_b = ALUSrcB;           r.alu_op = ALUOp;
    r.load_aout = LoadAOut;      r.reg_write = RegWrite;
    r.load_reg_a = LoadRegA;     r.load_reg_b = LoadRegB;     r.mem_to_reg = MemToReg;
    r.dmem_op = DMemOp;          r.load_mdr = LoadMDR;
    r.load_splice = LoadSplice;  r.store_splice = StoreSplice;
    r.imem_read = IMemRead;      r.ir_write = IRWrite;
    r.epc_write = EPCWrite;      r.cause_write = CauseWrite;
    r.int_cause = IntCause;      r.halted = halted;
    return r;
  endfunction

  // Only the signals that must be quiet while reset is held.
  function automatic rec_t masked(rec_t r);
    rec_t m = '0;
    m.pc_write = r.pc_write;   m.pc_write_cond = r.pc_write_cond;
    m.pc_write_state = r.pc_write_state;
    m.reg_write = r.reg_write; m.dmem_op = r.dmem_op;   m.ir_write = r.ir_write;
    m.epc_write = r.epc_write; m.cause_write = r.cause_write;
    return m;
  endfunction

  task automatic chk(input string tag, input rec_t obs, input rec_t expv);
    checks++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
  endtask

  function automatic bit known_opcode(input logic [6:0] opc);
    return opc inside {7'h33, 7'h13, 7'h37, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h73};
  endfunction

  // Expected per-cycle control words from FETCH until the next FETCH; returns 1 if the
  // instruction ends the program (EXC and/or HALT).
  function automatic bit build(input logic [31:0] ins, input logic eq, input logic gt,
                               input logic lt);
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [3:0] op;
    rec_t r, alu_rec, wb_rec, inc_rec;
    bit ok, term, tk;
    opc = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    ok = 1'b1; term = 1'b0; op = 4'd0; tk = 1'b0;
    exp_q.delete();
    r = '0; r.imem_read = 1'b1; exp_q.push_back(r);
    r = '0; r.ir_write = 1'b1; exp_q.push_back(r);
    r = '0; r.load_reg_a = 1'b1; r.load_reg_b = 1'b1; r.load_aout = 1'b1;
    r.src_b = 2'b10; r.alu_op = 4'd1; exp_q.push_back(r);
    alu_rec = '0; alu_rec.src_a = 2'b01; alu_rec.src_b = 2'b10; alu_rec.alu_op = 4'd1;
    alu_rec.load_aout = 1'b1;
    wb_rec = '0; wb_rec.reg_write = 1'b1;
    inc_rec = '0; inc_rec.src_b = 2'b01; inc_rec.alu_op = 4'd1; inc_rec.pc_write = 1'b1;
    inc_rec.pc_write_state = 1'b1;
    case (opc)
      7'h33: begin
        if (f3 == 3'd0 && f7 == 7'h00)      op = 4'd1;
        else if (f3 == 3'd0 && f7 == 7'h20) op = 4'd2;
        else if (f3 == 3'd7)                op = 4'd3;
        else if (f3 == 3'd6)                op = 4'd4;
        else if (f3 == 3'd4)                op = 4'd5;
        else                                ok = 1'b0;
        r = '0;
        if (ok) begin r.src_a = 2'b01; r.alu_op = op; r.load_aout = 1'b1; end
        exp_q.push_back(r);
        if (ok) begin exp_q.push_back(wb_rec); exp_q.push_back(inc_rec); end
      end
      7'h13: begin
        ok = (f3 == 3'd0);
        exp_q.push_back(ok ? alu_rec : zero_rec);
        if (ok) begin exp_q.push_back(wb_rec); exp_q.push_back(inc_rec); end
      end
      7'h37: begin
        r = alu_rec; r.src_a = 2'b10;
        exp_q.push_back(r); exp_q.push_back(wb_rec); exp_q.push_back(inc_rec);
      end
      7'h03, 7'h23: begin
        ok = (f3 < 3'd4);
        if (ok) begin
          exp_q.push_back(alu_rec);
          if (opc == 7'h03) begin
            exp_q.push_back(zero_rec);
            r = '0; r.load_mdr = 1'b1; exp_q.push_back(r);
            r = '0; r.reg_write = 1'b1; r.mem_to_reg = 2'b01; r.load_splice = 2'(3 - f3);
            exp_q.push_back(r);
          end else begin
            r = '0; r.dmem_op = 1'b1; r.store_splice = 2'(3 - f3); exp_q.push_back(r);
          end
          exp_q.push_back(inc_rec);
        end
      end
      7'h63: begin
        case (f3)
          3'd0:    tk = eq;
          3'd1:    tk = !eq;
          3'd4:    tk = lt;
          3'd5:    tk = gt || eq;
          default: ok = 1'b0;
        endcase
        r = '0; r.src_a = 2'b01; r.alu_op = 4'd2; r.pc_write_cond = 1'b1; r.pc_source = 1'b1;
        r.pc_write_state = ok && tk;
        exp_q.push_back(r);
        if (ok && !tk) exp_q.push_back(inc_rec);
      end
      7'h6F: begin
        exp_q.push_back(inc_rec);
        r = '0; r.reg_write = 1'b1; r.mem_to_reg = 2'b10; r.pc_source = 1'b1;
        r.pc_write = 1'b1; r.pc_write_state = 1'b1;
        exp_q.push_back(r);
      end
      7'h73:   term = 1'b1;
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      r = '0; r.epc_write = 1'b1; r.cause_write = 1'b1; exp_q.push_back(r);
      term = 1'b1;
    end
    if (term) begin
      r = '0; r.halted = 1'b1;
      repeat (20) exp_q.push_back(r);
    end
    return term;
  endfunction

  // Called at 1 time unit after a rising edge with the DUT in FETCH.
  task automatic run_instr(input string name, input logic [31:0] ins, input logic eq,
                           input logic gt, input logic lt, input int abort_at);
    bit term, aborted;
    aborted = 1'b0;
    instruction_in = ins;
    alu_equal = eq; alu_greater = gt; alu_less = lt; alu_zero = eq;
    term = build(ins, eq, gt, lt);
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k == abort_at) begin
        reset = 1'b1;
        #1;
        chk($sformatf("%s rst_mask c%0d", name, k), masked(observed()), zero_rec);
        @(posedge clk); #1;
        reset = 1'b0;
        aborted = 1'b1;
        break;
      end
      chk($sformatf("%s %08h c%0d", name, ins, k), observed(), exp_q[k]);
      @(posedge clk); #1;
    end
    if (term && !aborted) begin
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
    end
  endtask

  logic [31:0] rins;
  logic [6:0]  opcodes [8] = '{7'h33, 7'h13, 7'h37, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h73};
  int          cls, abort_at;
  rec_t        fetch_rec;

  initial begin
    fetch_rec = '0;
    fetch_rec.imem_read = 1'b1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("reset_hold", masked(observed()), zero_rec);
    reset = 1'b0;

    run_instr("add",      32'h002081B3, 1'b0, 1'b0, 1'b0, -1);
    run_instr("ld",       32'h0080B283, 1'b0, 1'b0, 1'b0, -1);
    run_instr("sb",       32'h00508023, 1'b0, 1'b0, 1'b0, -1);
    run_instr("beq_t",    32'h00208463, 1'b1, 1'b0, 1'b0, -1);
    run_instr("beq_nt",   32'h00208463, 1'b0, 1'b1, 1'b0, -1);
    run_instr("jal",      32'h010000EF, 1'b0, 1'b0, 1'b0, -1);
    run_instr("bad_op",   32'h0000007F, 1'b0, 1'b0, 1'b0, -1);
    run_instr("sb_rst",   32'h00508023, 1'b0, 1'b0, 1'b0, 4);
    run_instr("halt_op",  32'h00000073, 1'b0, 1'b0, 1'b0, -1);
    run_instr("after_rst", 32'h002081B3, 1'b0, 1'b0, 1'b0, -1);

    for (int n = 0; n < 300; n++) begin
      rins = $urandom;
      cls = $urandom_range(0, 8);
      if (cls < 8) begin
        rins[6:0] = opcodes[cls];
        if (cls == 0) begin
          case ($urandom_range(0, 3))
            0:       rins[31:25] = 7'h00;
            1:       rins[31:25] = 7'h20;
            default: ;
          endcase
        end
      end else begin
        do rins[6:0] = 7'($urandom); while (known_opcode(rins[6:0]));
      end
      abort_at = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 9)) : -1;
      run_instr("rand", rins, 1'($urandom), 1'($urandom), 1'($urandom), abort_at);
    end

    chk("final_fetch", observed(), fetch_rec);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have exactly one clock and a synchronous, active-high reset: clk (rising edge) and reset.
REQ-002 SHALL have the following ports (name  direction  width  meaning), with clk and reset listed first:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- instruction_in  in  32  current IR contents, from processing.instruction_out
- alu_zero, alu_equal, alu_greater, alu_less  in  1 each  ALU flags
- PCWrite, PCWriteCond, PCWriteState, PCSource  out  1 each  PC control
- ALUSrcA, ALUSrcB  out  2 each  ALU operand selects
- ALUOp  out  4  ALU function
- LoadAOut, RegWrite, LoadRegA, LoadRegB  out  1 each  register loads
- MemToReg  out  2  register-file write-data select
- DMemOp, LoadMDR  out  1 each  data memory write, MDR load
- LoadSplice, StoreSplice  out  2 each  access-size select
- IMemRead, IRWrite  out  1 each  instruction memory read, IR load
- EPCWrite, CauseWrite, IntCause  out  1 each  exception capture
- halted  out  1  core stopped

Function
REQ-003 SHALL be a Moore FSM with states FETCH, IR_LOAD, DECODE, EXEC_R, EXEC_I, EXEC_LUI, WB_ALU, MEM_ADDR, MEM_READ, MEM_WAIT, WB_MEM, MEM_WRITE, BRANCH, JAL_LINK, JAL_WB, PC_INC, EXC, HALT.
REQ-004 SHALL drive every output not listed for the current state as 0.
REQ-005 SHALL use these ALUOp codes: ADD=0001, SUB=0010, AND=0011, OR=0100, XOR=0101.
REQ-006 SHALL generate PCWriteState combinationally as PCWrite | (PCWriteCond & taken).
REQ-007 FETCH SHALL assert IMemRead and go to IR_LOAD.
REQ-008 IR_LOAD SHALL assert IRWrite and go to DECODE.
REQ-009 DECODE SHALL assert LoadRegA, LoadRegB, LoadAOut, ALUSrcA=00, ALUSrcB=10 and ALUOp=ADD, which stores the target PC+imm in ALUOut.
REQ-010 DECODE SHALL dispatch on opcode bits [6:0] as follows:
- 0110011 -> EXEC_R
- 0010011 -> EXEC_I
- 0110111 -> EXEC_LUI
- 0000011 or 0100011 -> MEM_ADDR
- 1100011 -> BRANCH
- 1101111 -> JAL_LINK
- 1110011 -> HALT
- any other opcode -> EXC
REQ-011 EXEC_R SHALL assert ALUSrcA=01, ALUSrcB=00 and LoadAOut, with ALUOp decoded from funct7/funct3 as follows:
- add 0000000/000 -> ADD
- sub 0100000/000 -> SUB
- and /111 -> AND
- or /110 -> OR
- xor /100 -> XOR
- any other R-type encoding -> EXC
REQ-012 EXEC_I SHALL assert ALUSrcA=01, ALUSrcB=10, ALUOp=ADD and LoadAOut when funct3=000, and SHALL go to EXC for any other funct3.
REQ-013 EXEC_LUI SHALL assert ALUSrcA=10, ALUSrcB=10, ALUOp=ADD and LoadAOut.
REQ-014 EXEC_R, EXEC_I and EXEC_LUI SHALL each go to WB_ALU on success.
REQ-015 WB_ALU SHALL assert RegWrite with MemToReg=00, then go to PC_INC.
REQ-016 MEM_ADDR SHALL assert ALUSrcA=01, ALUSrcB=10, ALUOp=ADD and LoadAOut, then go to MEM_READ for loads and MEM_WRITE for stores.
REQ-017 For loads, MEM_READ SHALL go to MEM_WAIT; MEM_WAIT SHALL assert LoadMDR; WB_MEM SHALL assert RegWrite with MemToReg=01 and LoadSplice, then go to PC_INC.
REQ-018 LoadSplice and StoreSplice SHALL be decoded from funct3: 011->00 (double), 010->01 (word), 001->10 (half), 000->11 (byte); any other funct3 in DECODE SHALL go to EXC.
REQ-019 MEM_WRITE SHALL assert DMemOp and StoreSplice, then go to PC_INC.
REQ-020 BRANCH SHALL assert ALUSrcA=01, ALUSrcB=00, ALUOp=SUB, PCWriteCond and PCSource=1, with LoadAOut=0.
REQ-021 In BRANCH, taken SHALL be decoded from funct3 as follows; any other funct3 -> EXC:
- beq 000: alu_equal
- bne 001: !alu_equal
- blt 100: alu_less
- bge 101: alu_greater | alu_equal
REQ-022 BRANCH SHALL go to FETCH when taken and to PC_INC when not taken.
REQ-023 JAL_LINK SHALL assert ALUSrcA=00, ALUSrcB=01, ALUOp=ADD, PCSource=0 and PCWrite (PC<=PC+4), with LoadAOut=0.
REQ-024 JAL_WB SHALL assert RegWrite with MemToReg=10 (writing PC+4), plus PCSource=1 and PCWrite (PC<=target), then go to FETCH.
REQ-025 PC_INC SHALL assert ALUSrcA=00, ALUSrcB=01, ALUOp=ADD, PCSource=0 and PCWrite, then go to FETCH.
REQ-026 EXC SHALL assert EPCWrite and CauseWrite with IntCause=0 for exactly one cycle, then go to HALT.
REQ-027 HALT SHALL assert halted, drive all other outputs 0, and remain until reset.
REQ-028 Instruction latencies from entering FETCH to re-entering FETCH SHALL be:
- R/I/LUI: 6 cycles
- load: 8 cycles
- store: 6 cycles
- branch taken: 4 cycles
- branch not taken: 5 cycles
- JAL: 5 cycles
REQ-029 No state SHALL assert RegWrite and DMemOp in the same cycle.

Reset
REQ-030 reset sampled high SHALL set the state to FETCH at that clock edge, from any state, including mid-instruction and HALT.
REQ-031 While reset is high, RegWrite, DMemOp, PCWrite, PCWriteCond, PCWriteState, IRWrite, EPCWrite and CauseWrite SHALL be forced to 0.
REQ-032 The first cycle after reset SHALL present FETCH outputs: IMemRead=1, halted=0, and all other outputs 0.

Verification
REQ-033 add x3,x1,x2 (0x002081B3) -> states FETCH, IR_LOAD, DECODE, EXEC_R, WB_ALU, PC_INC; ALUOp=0001 in EXEC_R; RegWrite=1 only in WB_ALU; PCWriteState=1 only in PC_INC.
REQ-034 ld x5,8(x1) (0x0080B283) -> 8-cycle sequence; LoadMDR=1 in MEM_WAIT; WB_MEM has MemToReg=01, LoadSplice=00; sb (funct3 000) -> DMemOp=1 with StoreSplice=11 for exactly one cycle.
REQ-035 beq (0x00208463) with alu_equal=1 in BRANCH -> PCWriteState=1 and PCSource=1, next state FETCH; the same instruction with alu_equal=0 -> PCWriteState=0 in BRANCH, then PC_INC.
REQ-036 jal x1,+16 (0x010000EF) -> JAL_LINK (PCWrite=1, PCSource=0), then JAL_WB (RegWrite=1, MemToReg=10, PCSource=1, PCWrite=1), then FETCH.
REQ-037 opcode 0x7F -> EXC for one cycle (EPCWrite=CauseWrite=1, IntCause=0), then HALT with halted=1 held for 20+ cycles.
REQ-038 reset asserted during MEM_WRITE -> DMemOp=0 in that cycle and FETCH on the next cycle; reset asserted in HALT -> halted=0 on the next cycle.
